four_channel_request_latch: RTL and testbench

Upstream request-capture stage for the 4:2 priority encoder. It latches four request lines into sticky pending bits and presents the masked pending vector to the encoder's 4-bit input. It also raises a single interrupt, accepts an acknowledge carrying the encoder's 2-bit index, clears that channel and tracks the in-service phase through end-of-interrupt. Per-channel overrun flags record lost events.

---
 rtl/four_channel_request_latch.sv | 61 ++++++
 tb/tb_four_channel_request_latch.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/four_channel_request_latch.sv
// four_channel_request_latch: sticky request capture with masked pending vector, irq/ack/eoi FSM and overrun flags
module four_channel_request_latch #(
  parameter bit          EDGE_MODE = 1'b1,
  parameter int unsigned HOLDOFF   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_in,
  input  logic [3:0] mask,
  input  logic       ack,
  input  logic [1:0] ack_idx,
  input  logic       eoi,
  input  logic       ovr_clr,
  output logic [3:0] pend_vec,
  output logic       irq,
  output logic       in_service,
  output logic [1:0] svc_idx,
  output logic [3:0] overrun
);
  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SERVICE, S_HOLDOFF} state_t;
  localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF);
  state_t state, nxt;
  logic [3:0] req_q, pending, rise, clr, new_ovr, cnt;
  logic accept;
  assign pend_vec = pending & mask;
  always_comb begin
    rise = EDGE_MODE ? req_in & ~req_q : req_in;
    accept = state == S_ASSERT && ack && pend_vec[ack_idx];
    clr = accept ? 4'b0001 << ack_idx : 4'b0000;
    new_ovr = EDGE_MODE ? rise & pending & ~clr : 4'b0000;
    nxt = state;
    case (state)
      S_IDLE:    nxt = |pend_vec ? S_ASSERT : S_IDLE;
      S_ASSERT:  nxt = accept ? S_SERVICE : (|pend_vec ? S_ASSERT : S_IDLE);
      S_SERVICE: nxt = eoi ? (HOLD_INIT == 4'd0 ? S_IDLE : S_HOLDOFF) : S_SERVICE;
      S_HOLDOFF: nxt = cnt <= 4'd1 ? S_IDLE : S_HOLDOFF;
      default:   nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      req_q <= 4'b0000;
      pending <= 4'b0000;
      overrun <= 4'b0000;
      svc_idx <= 2'd0;
      cnt <= 4'd0;
      irq <= 1'b0;
      in_service <= 1'b0;
    end else begin
      state <= nxt;
      req_q <= req_in;
      pending <= (pending & ~clr) | rise;
      overrun <= (ovr_clr ? 4'b0000 : overrun) | new_ovr;
      if (accept) svc_idx <= ack_idx;
      cnt <= (state == S_SERVICE && eoi) ? HOLD_INIT : (cnt != 4'd0 ? cnt - 4'd1 : cnt);
      irq <= nxt == S_ASSERT;
      in_service <= nxt == S_SERVICE;
    end
  end
endmodule

// File: tb/tb_four_channel_request_latch.sv
// tb_four_channel_request_latch: directed scoreboard bench for the request latch (EDGE_MODE=1, HOLDOFF=2)
module tb_four_channel_request_latch;
  logic clk = 1'b0, rst_n = 1'b0, ack = 1'b0, eoi = 1'b0, ovr_clr = 1'b0;
  logic [3:0] req_in = 4'hF, mask = 4'hF;
  logic [1:0] ack_idx = 2'd0;
  logic [3:0] pend_vec, overrun;
  logic irq, in_service;
  logic [1:0] svc_idx;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    string tag;
    logic [3:0] pv;
    logic ir;
    logic is;
    logic [1:0] si;
    logic [3:0] ov;
  } exp_t;
  exp_t sb[$];
  four_channel_request_latch #(.EDGE_MODE(1'b1), .HOLDOFF(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask(mask), .ack(ack), .ack_idx(ack_idx),
    .eoi(eoi), .ovr_clr(ovr_clr), .pend_vec(pend_vec), .irq(irq), .in_service(in_service),
    .svc_idx(svc_idx), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask
  task automatic step(input string tag, input logic [3:0] pv, input logic ir, input logic is,
                      input logic [1:0] si, input logic [3:0] ov);
    exp_t e;
    e.tag = tag; e.pv = pv; e.ir = ir; e.is = is; e.si = si; e.ov = ov;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".pend_vec"}, 32'(pend_vec), 32'(e.pv));
    check({e.tag, ".irq"}, 32'(irq), 32'(e.ir));
    check({e.tag, ".in_service"}, 32'(in_service), 32'(e.is));
    check({e.tag, ".svc_idx"}, 32'(svc_idx), 32'(e.si));
    check({e.tag, ".overrun"}, 32'(overrun), 32'(e.ov));
    ack = 1'b0; eoi = 1'b0; ovr_clr = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    // 1: reset with lines high, then release produces a rise on every channel
    step("rst0", 4'h0, 0, 0, 2'd0, 4'h0);
    step("rst1", 4'h0, 0, 0, 2'd0, 4'h0);
    rst_n = 1'b1;
    step("rel_pend", 4'hF, 0, 0, 2'd0, 4'h0);
    step("rel_irq", 4'hF, 1, 0, 2'd0, 4'h0);
    rst_n = 1'b0; req_in = 4'h0;
    step("rst_mid", 4'h0, 0, 0, 2'd0, 4'h0);
    rst_n = 1'b1;
    step("rst_out", 4'h0, 0, 0, 2'd0, 4'h0);
    // 2: single request through full service cycle
    req_in = 4'b0100;
    step("t2_set", 4'b0100, 0, 0, 2'd0, 4'h0);
    req_in = 4'h0;
    step("t2_irq", 4'b0100, 1, 0, 2'd0, 4'h0);
    ack = 1'b1; ack_idx = 2'd2;
    step("t2_ack", 4'h0, 0, 1, 2'd2, 4'h0);
    step("t2_svc", 4'h0, 0, 1, 2'd2, 4'h0);
    eoi = 1'b1;
    step("t2_eoi", 4'h0, 0, 0, 2'd2, 4'h0);
    step("t2_hold", 4'h0, 0, 0, 2'd2, 4'h0);
    step("t2_idle", 4'h0, 0, 0, 2'd2, 4'h0);
    step("t2_idle2", 4'h0, 0, 0, 2'd2, 4'h0);
    // 3: two requests, re-assert after holdoff
    req_in = 4'b1001;
    step("t3_set", 4'b1001, 0, 0, 2'd2, 4'h0);
    req_in = 4'h0;
    step("t3_irq", 4'b1001, 1, 0, 2'd2, 4'h0);
    ack = 1'b1; ack_idx = 2'd3;
    step("t3_ack3", 4'b0001, 0, 1, 2'd3, 4'h0);
    eoi = 1'b1;
    step("t3_eoi", 4'b0001, 0, 0, 2'd3, 4'h0);
    step("t3_hold", 4'b0001, 0, 0, 2'd3, 4'h0);
    step("t3_idle", 4'b0001, 0, 0, 2'd3, 4'h0);
    step("t3_reirq", 4'b0001, 1, 0, 2'd3, 4'h0);
    ack = 1'b1; ack_idx = 2'd0;
    step("t3_ack0", 4'h0, 0, 1, 2'd0, 4'h0);
    eoi = 1'b1;
    step("t3_eoi2", 4'h0, 0, 0, 2'd0, 4'h0);
    step("t3_hold2", 4'h0, 0, 0, 2'd0, 4'h0);
    step("t3_idle2", 4'h0, 0, 0, 2'd0, 4'h0);
    // 4: overrun, clear, and new overrun beating clear
    req_in = 4'b0010;
    step("t4_set", 4'b0010, 0, 0, 2'd0, 4'h0);
    req_in = 4'h0;
    step("t4_irq", 4'b0010, 1, 0, 2'd0, 4'h0);
    req_in = 4'b0010;
    step("t4_ovr", 4'b0010, 1, 0, 2'd0, 4'b0010);
    req_in = 4'h0; ovr_clr = 1'b1;
    step("t4_clr", 4'b0010, 1, 0, 2'd0, 4'h0);
    req_in = 4'b0010;
    step("t4_ovr2", 4'b0010, 1, 0, 2'd0, 4'b0010);
    req_in = 4'h0;
    step("t4_low", 4'b0010, 1, 0, 2'd0, 4'b0010);
    req_in = 4'b0010; ovr_clr = 1'b1;
    step("t4_setwins", 4'b0010, 1, 0, 2'd0, 4'b0010);
    req_in = 4'h0; ovr_clr = 1'b1;
    step("t4_clr2", 4'b0010, 1, 0, 2'd0, 4'h0);
    ack = 1'b1; ack_idx = 2'd1;
    step("t4_ack", 4'h0, 0, 1, 2'd1, 4'h0);
    eoi = 1'b1;
    step("t4_eoi", 4'h0, 0, 0, 2'd1, 4'h0);
    step("t4_hold", 4'h0, 0, 0, 2'd1, 4'h0);
    step("t4_idle", 4'h0, 0, 0, 2'd1, 4'h0);
    // 5: masked request, invalid ack, mask removal drops back to idle
    mask = 4'h0; req_in = 4'b0001;
    step("t5_masked", 4'h0, 0, 0, 2'd1, 4'h0);
    req_in = 4'h0;
    step("t5_quiet", 4'h0, 0, 0, 2'd1, 4'h0);
    mask = 4'b0001;
    step("t5_unmask", 4'b0001, 1, 0, 2'd1, 4'h0);
    ack = 1'b1; ack_idx = 2'd1;
    step("t5_badack", 4'b0001, 1, 0, 2'd1, 4'h0);
    mask = 4'h0;
    step("t5_remask", 4'h0, 0, 0, 2'd1, 4'h0);
    mask = 4'hF;
    step("t5_reirq", 4'b0001, 1, 0, 2'd1, 4'h0);
    ack = 1'b1; ack_idx = 2'd0;
    step("t5_ack", 4'h0, 0, 1, 2'd0, 4'h0);
    eoi = 1'b1;
    step("t5_eoi", 4'h0, 0, 0, 2'd0, 4'h0);
    step("t5_hold", 4'h0, 0, 0, 2'd0, 4'h0);
    step("t5_idle", 4'h0, 0, 0, 2'd0, 4'h0);
    // 6: same-cycle set and clear on channel 2, then reset while in service
    req_in = 4'b0100;
    step("t6_set", 4'b0100, 0, 0, 2'd0, 4'h0);
    req_in = 4'h0;
    step("t6_irq", 4'b0100, 1, 0, 2'd0, 4'h0);
    req_in = 4'b0100; ack = 1'b1; ack_idx = 2'd2;
    step("t6_setclr", 4'b0100, 0, 1, 2'd2, 4'h0);
    req_in = 4'h0;
    step("t6_svc", 4'b0100, 0, 1, 2'd2, 4'h0);
    rst_n = 1'b0;
    step("t6_rst", 4'h0, 0, 0, 2'd0, 4'h0);
    rst_n = 1'b1;
    step("t6_after", 4'h0, 0, 0, 2'd0, 4'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
